// File: rtl/fifo_rd_ctl.sv
// fifo_rd_ctl
// Read-side controller of a dual-clock FIFO, living entirely in the read
// (destination) clock domain. It takes the binary write pointer delivered by
// the upstream Gray-code synchronizer, keeps the local read pointer, and
// derives the RAM read address, pop acceptance, occupancy flags and error
// status.
//
// Ports
//   clk           in   read-domain clock, rising edge
//   rst_n         in   asynchronous active-low reset
//   init_n        in   synchronous active-low init (same effect as reset)
//   wr_count_d    in   [pw-1:0] synchronized binary write pointer, mod 2^pw
//   pop_req_n     in   active-low pop request
//   rd_en         out  pop accepted this cycle (combinational); RAM read
//                      enable and en_s of the return-path synchronizer
//   rd_addr       out  [addr_width-1:0] RAM read address (low bits of rd_ptr)
//   rd_ptr        out  [pw-1:0] registered binary read pointer
//   word_count    out  [pw-1:0] registered number of valid words, 0..depth
//   empty         out  registered, word_count == 0
//   almost_empty  out  registered, word_count <= ae_level
//   underflow     out  registered, pop requested while empty
//   ptr_err       out  registered, sticky; write pointer inconsistent with
//                      the read pointer
//
// Handshake: a pop request (pop_req_n low) is accepted in exactly the cycle
// rd_en is high, i.e. when the FIFO is not empty, no pointer error is
// latched and init is not asserted. There is no back-pressure beyond that:
// a request seen while empty is not retried, it is reported as underflow.
module fifo_rd_ctl #(
  parameter int addr_width = 4,
  parameter int ae_level   = 2,
  parameter int err_mode   = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  init_n,
  input  logic [addr_width:0]   wr_count_d,
  input  logic                  pop_req_n,
  output logic                  rd_en,
  output logic [addr_width-1:0] rd_addr,
  output logic [addr_width:0]   rd_ptr,
  output logic [addr_width:0]   word_count,
  output logic                  empty,
  output logic                  almost_empty,
  output logic                  underflow,
  output logic                  ptr_err
);

  localparam int pw    = addr_width + 1;
  localparam int depth = 1 << addr_width;

  logic [pw-1:0] rd_ptr_nxt;
  logic [pw-1:0] nxt_cnt;
  logic          cnt_bad;
  logic          uflow_evt;

  // Init wins over a simultaneous pop, so it also suppresses acceptance.
  assign rd_en = !pop_req_n && !empty && !ptr_err && init_n;

  assign rd_ptr_nxt = rd_ptr + {{(pw-1){1'b0}}, rd_en};

  // Modulo-2^pw difference: the extra pointer bit keeps full (depth) and
  // empty (0) distinct and makes the count correct across pointer wrap.
  assign nxt_cnt = wr_count_d - rd_ptr_nxt;

  // More than depth words can never be legitimately outstanding.
  assign cnt_bad = nxt_cnt > pw'(depth);

  assign uflow_evt = !pop_req_n && empty;

  assign rd_addr = rd_ptr[addr_width-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr       <= '0;
      word_count   <= '0;
      empty        <= 1'b1;
      almost_empty <= 1'b1;
      underflow    <= 1'b0;
      ptr_err      <= 1'b0;
    end else if (!init_n) begin
      rd_ptr       <= '0;
      word_count   <= '0;
      empty        <= 1'b1;
      almost_empty <= 1'b1;
      underflow    <= 1'b0;
      ptr_err      <= 1'b0;
    end else begin
      rd_ptr <= rd_ptr_nxt;
      // An inconsistent count is never published; the last good count and
      // flags are held and the error latches.
      if (cnt_bad) begin
        ptr_err <= 1'b1;
      end else begin
        word_count   <= nxt_cnt;
        empty        <= (nxt_cnt == '0);
        almost_empty <= (nxt_cnt <= pw'(ae_level));
      end
      if (err_mode != 0) begin
        underflow <= uflow_evt;
      end else begin
        underflow <= underflow | uflow_evt;
      end
    end
  end

endmodule

// File: tb/tb_fifo_rd_ctl.sv
// Testbench for fifo_rd_ctl: two instances (sticky and per-cycle underflow)
// share one stimulus stream; a behavioural occupancy model predicts every
// output each cycle.
module tb_fifo_rd_ctl;

  localparam int AW    = 4;
  localparam int PW    = AW + 1;
  localparam int DEPTH = 1 << AW;
  localparam int NPTR  = 1 << PW;
  localparam int AE    = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          init_n;
  logic [PW-1:0] wr_count_d;
  logic          pop_req_n;

  logic          rd_en, empty, almost_empty, underflow, ptr_err;
  logic [AW-1:0] rd_addr;
  logic [PW-1:0] rd_ptr, word_count;

  logic          rd_en1, empty1, almost_empty1, underflow1, ptr_err1;
  logic [AW-1:0] rd_addr1;
  logic [PW-1:0] rd_ptr1, word_count1;

  fifo_rd_ctl #(.addr_width(AW), .ae_level(AE), .err_mode(0)) dut (
    .clk(clk), .rst_n(rst_n), .init_n(init_n), .wr_count_d(wr_count_d),
    .pop_req_n(pop_req_n), .rd_en(rd_en), .rd_addr(rd_addr), .rd_ptr(rd_ptr),
    .word_count(word_count), .empty(empty), .almost_empty(almost_empty),
    .underflow(underflow), .ptr_err(ptr_err)
  );

  fifo_rd_ctl #(.addr_width(AW), .ae_level(AE), .err_mode(1)) dut_m1 (
    .clk(clk), .rst_n(rst_n), .init_n(init_n), .wr_count_d(wr_count_d),
    .pop_req_n(pop_req_n), .rd_en(rd_en1), .rd_addr(rd_addr1), .rd_ptr(rd_ptr1),
    .word_count(word_count1), .empty(empty1), .almost_empty(almost_empty1),
    .underflow(underflow1), .ptr_err(ptr_err1)
  );

  // ---------------- scoreboard / reference model ----------------
  int n_vec = 0;
  int n_err = 0;

  // Model in terms of pointers and occupancy as plain integers.
  int m_rd;      // read pointer, 0..NPTR-1
  int m_cnt;     // published word count
  bit m_err;     // pointer error latched
  bit m_uf0;     // sticky underflow
  bit m_uf1;     // per-cycle underflow
  int wr_ptr;    // write pointer the bench presents

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_rd = 0; m_cnt = 0; m_err = 0; m_uf0 = 0; m_uf1 = 0;
  endtask

  task automatic check_outputs();
    check_eq("rd_ptr", rd_ptr, m_rd);
    check_eq("rd_addr", rd_addr, m_rd % DEPTH);
    check_eq("word_count", word_count, m_cnt);
    check_eq("empty", empty, m_cnt == 0);
    check_eq("almost_empty", almost_empty, m_cnt <= AE);
    check_eq("underflow", underflow, m_uf0);
    check_eq("ptr_err", ptr_err, m_err);
    check_eq("underflow_m1", underflow1, m_uf1);
  endtask

  // ---------------- driver ----------------
  // Entered shortly after a rising edge; drives one cycle of inputs, checks
  // rd_en mid-cycle, advances the model at the edge and checks the result.
  task automatic cycle(input bit pop, input int wr, input bit init);
    int acc;
    int new_rd;
    int n;
    bit uf;
    pop_req_n  = !pop;
    wr_count_d = PW'(wr % NPTR);
    init_n     = !init;
    #4;
    acc = (!init && pop && m_cnt != 0 && !m_err) ? 1 : 0;
    check_eq("rd_en", rd_en, acc);
    check_eq("rd_en_m1", rd_en1, acc);
    @(posedge clk);
    if (init) begin
      model_reset();
    end else begin
      uf     = pop && (m_cnt == 0);
      new_rd = (m_rd + acc) % NPTR;
      n      = ((wr % NPTR) - new_rd + NPTR) % NPTR;
      if (n > DEPTH) m_err = 1;
      else m_cnt = n;
      m_uf0 = m_uf0 | uf;
      m_uf1 = uf;
      m_rd  = new_rd;
    end
    #1;
    check_outputs();
  endtask

  task automatic do_init();
    wr_ptr = 0;
    cycle(1'b0, 0, 1'b1);
  endtask

  // Reset asserted in the middle of a cycle must take effect before the edge.
  task automatic async_reset_check();
    pop_req_n = 1'b0;
    init_n    = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs();
    check_eq("rd_en_in_reset", rd_en, 0);
    @(posedge clk);
    #1;
    check_outputs();
    rst_n      = 1'b1;
    wr_ptr     = 0;
    wr_count_d = '0;
    pop_req_n  = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int room;
    int inc;
    bit pop;
    rst_n      = 1'b0;
    init_n     = 1'b1;
    pop_req_n  = 1'b1;
    wr_count_d = '0;
    wr_ptr     = 0;
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    check_outputs();
    check_eq("rd_en_after_reset", rd_en, 0);
    rst_n = 1'b1;

    // Fill to depth, then drain with back-to-back pops, then underflow.
    wr_ptr = DEPTH;
    cycle(1'b0, wr_ptr, 1'b0);
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, wr_ptr, 1'b0);
    for (int i = 0; i < 2; i++) cycle(1'b1, wr_ptr, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b0, wr_ptr, 1'b0);
    do_init();

    // Walk the read pointer to 30, then wrap through 31, 0, 1.
    while (m_rd != 30) cycle(1'b1, (m_rd + 2) % NPTR, 1'b0);
    wr_ptr = 1;
    cycle(1'b0, wr_ptr, 1'b0);
    check_eq("wrap_count", word_count, 3);
    for (int i = 0; i < 3; i++) cycle(1'b1, wr_ptr, 1'b0);
    check_eq("wrap_empty", empty, 1);
    cycle(1'b1, wr_ptr, 1'b0);
    do_init();

    // Write advance and pop in the same cycle net out.
    wr_ptr = 5;
    cycle(1'b0, wr_ptr, 1'b0);
    wr_ptr = 6;
    cycle(1'b1, wr_ptr, 1'b0);
    check_eq("net_count", word_count, 5);

    // Init together with a pop request: no pop, pointer back to 0.
    cycle(1'b1, wr_ptr, 1'b1);
    wr_ptr = 0;

    // Pointer error: write pointer too far ahead; pops blocked until init.
    cycle(1'b0, 3, 1'b0);
    cycle(1'b0, 20, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b1, 20, 1'b0);
    do_init();

    // Randomized traffic with an always-consistent write pointer.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 59) == 0) begin
        do_init();
      end else begin
        room = DEPTH - ((wr_ptr - m_rd + NPTR) % NPTR);
        inc  = $urandom_range(0, (room < 3) ? room : 3);
        wr_ptr = (wr_ptr + inc) % NPTR;
        pop  = ($urandom_range(0, 9) < 6);
        cycle(pop, wr_ptr, 1'b0);
      end
    end

    // Asynchronous reset in the middle of activity.
    wr_ptr = (m_rd + 4) % NPTR;
    cycle(1'b0, wr_ptr, 1'b0);
    async_reset_check();
    cycle(1'b1, 0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
